// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the AHB-to-APB bridge.
// Qualifies address phases, decodes the APB peripheral window, pipelines
// address/data/direction for the APB FSM, and produces the two-cycle ERROR
// response for illegal transfers.
module ahb_slave_interface #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter int unsigned WIN_BITS  = 26,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                Hclk,
  input  logic                Hreset,
  input  logic                Hwrite,
  input  logic                Hreadyin,
  input  logic [1:0]          Htrans,
  input  logic [2:0]          Hsize,
  input  logic [31:0]         Haddr,
  input  logic [31:0]         Hwdata,
  input  logic [31:0]         Prdata,
  input  logic                Hreadyout_apb,
  output logic                valid,
  output logic [2:0]          tempselx,
  output logic [31:0]         Haddr1,
  output logic [31:0]         Haddr2,
  output logic [31:0]         Hwdata1,
  output logic [31:0]         Hwdata2,
  output logic                Hwritereg,
  output logic [31:0]         Hrdata,
  output logic [1:0]          Hresp,
  output logic                Hreadyout,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [1:0] ST_OKAY = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [ERRCNT_W-1:0] ErrMax = {ERRCNT_W{1'b1}};
  localparam logic [ERRCNT_W-1:0] ErrOne = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state_q, state_d;
  logic       active;
  logic       size_bad;
  logic       illegal;

  // Htrans[0] only separates NONSEQ/SEQ and IDLE/BUSY; activity is Htrans[1].
  logic unused_htrans0;
  assign unused_htrans0 = Htrans[0];

  // Peripheral window decode on the upper address bits.
  always_comb begin
    tempselx = 3'b000;
    if (Haddr[31:WIN_BITS] == SLV0_BASE[31:WIN_BITS]) begin
      tempselx = 3'b001;
    end else if (Haddr[31:WIN_BITS] == SLV1_BASE[31:WIN_BITS]) begin
      tempselx = 3'b010;
    end else if (Haddr[31:WIN_BITS] == SLV2_BASE[31:WIN_BITS]) begin
      tempselx = 3'b100;
    end
  end

  // Transfer qualification: unmapped, oversize or misaligned phases are illegal.
  always_comb begin
    active   = Htrans[1];
    size_bad = (Hsize > 3'b010) ||
               ((Hsize == 3'b001) && Haddr[0]) ||
               ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00));
    illegal  = active && Hreadyin && ((tempselx == 3'b000) || size_bad);
    valid    = active && Hreadyin && !illegal && (state_q == ST_OKAY);
  end

  // Error FSM next state; an illegal phase during ERR2 starts a new sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OKAY: state_d = illegal ? ST_ERR1 : ST_OKAY;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = illegal ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  // Bus response mux: FSM ready when OKAY, two-cycle ERROR otherwise.
  always_comb begin
    Hreadyout = Hreadyout_apb;
    Hresp     = RESP_OKAY;
    unique case (state_q)
      ST_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = RESP_ERROR;
      end
      ST_ERR2: begin
        Hreadyout = 1'b1;
        Hresp     = RESP_ERROR;
      end
      default: begin
        Hreadyout = Hreadyout_apb;
        Hresp     = RESP_OKAY;
      end
    endcase
  end

  // Error state register and saturating error counter.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q   <= ST_OKAY;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == ST_ERR1) && (err_count != ErrMax)) begin
        err_count <= err_count + ErrOne;
      end
    end
  end

  // Address/data/direction pipeline; advances only on completed phases.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  // Read data passes straight through from the APB side.
  always_comb begin
    Hrdata = Prdata;
  end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Self-checking bench for ahb_slave_interface using scoreboard queues.
module tb_ahb_slave_interface;

  logic        Hclk;
  logic        Hreset;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Hreadyout_apb;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata1;
  logic [31:0] Hwdata2;
  logic        Hwritereg;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
  } addr_t;

  typedef struct packed {
    logic       rdy;
    logic [1:0] resp;
  } rsp_t;

  addr_t       addr_q[$];
  logic [31:0] data_q[$];
  rsp_t        rsp_q[$];

  int n_tests;
  int n_fail;
  int exp_err;

  ahb_slave_interface dut (
    .Hclk          (Hclk),
    .Hreset        (Hreset),
    .Hwrite        (Hwrite),
    .Hreadyin      (Hreadyin),
    .Htrans        (Htrans),
    .Hsize         (Hsize),
    .Haddr         (Haddr),
    .Hwdata        (Hwdata),
    .Prdata        (Prdata),
    .Hreadyout_apb (Hreadyout_apb),
    .valid         (valid),
    .tempselx      (tempselx),
    .Haddr1        (Haddr1),
    .Haddr2        (Haddr2),
    .Hwdata1       (Hwdata1),
    .Hwdata2       (Hwdata2),
    .Hwritereg     (Hwritereg),
    .Hrdata        (Hrdata),
    .Hresp         (Hresp),
    .Hreadyout     (Hreadyout),
    .err_count     (err_count)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Advance past the next rising edge; outputs are stable 1ns later.
  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive_idle();
    Htrans   = 2'b00;
    Hreadyin = 1'b1;
    Hwrite   = 1'b0;
  endtask

  task automatic drive_phase(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    Haddr    = a;
    Hsize    = sz;
    Hwrite   = wr;
    Htrans   = 2'b10;
    Hreadyin = 1'b1;
  endtask

  // Pop one expected response and compare against the bus.
  task automatic check_rsp(input string name);
    rsp_t e;
    n_tests++;
    if (rsp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: response scoreboard empty", name);
    end else begin
      e = rsp_q.pop_front();
      if ({Hreadyout, Hresp} !== {e.rdy, e.resp}) begin
        n_fail++;
        $display("FAIL %s: got rdy=%b resp=%b, want rdy=%b resp=%b",
                 name, Hreadyout, Hresp, e.rdy, e.resp);
      end
    end
  endtask

  task automatic test_reset();
    Hreset        = 1'b1;
    Hreadyout_apb = 1'b0;
    step();
    n_tests++;
    if ({Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h %h %h %h %b %h, want all zero",
               Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, err_count);
    end
    n_tests++;
    if ({Hreadyout, Hresp} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rsp_lo: got rdy=%b resp=%b, want 0 00", Hreadyout, Hresp);
    end
    Hreadyout_apb = 1'b1;
    #1;
    n_tests++;
    if ({Hreadyout, Hresp} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_rsp_hi: got rdy=%b resp=%b, want 1 00", Hreadyout, Hresp);
    end
    Hreset  = 1'b0;
    exp_err = 0;
  endtask

  task automatic test_write();
    addr_t e;
    logic [31:0] d;
    drive_phase(32'h8000_0010, 3'b010, 1'b1);
    #1;
    n_tests++;
    if ({valid, tempselx} !== 4'b1001) begin
      n_fail++;
      $display("FAIL write_decode: got valid=%b sel=%b, want 1 001", valid, tempselx);
    end
    addr_q.push_back('{addr: 32'h8000_0010, wr: 1'b1});
    step();
    drive_idle();
    Hwdata = 32'hA5A5_0001;
    data_q.push_back(32'hA5A5_0001);
    e = addr_q.pop_front();
    n_tests++;
    if ({Haddr1, Hwritereg} !== {e.addr, e.wr}) begin
      n_fail++;
      $display("FAIL write_addr: got %h wr=%b, want %h wr=%b", Haddr1, Hwritereg, e.addr, e.wr);
    end
    step();
    Hwdata = 32'h0;
    d = data_q.pop_front();
    n_tests++;
    if (Hwdata1 !== d) begin
      n_fail++;
      $display("FAIL write_data1: got %h, want %h", Hwdata1, d);
    end
    step();
    n_tests++;
    if (Hwdata2 !== d) begin
      n_fail++;
      $display("FAIL write_data2: got %h, want %h", Hwdata2, d);
    end
    Prdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (Hrdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rdata_pass: got %h, want deadbeef", Hrdata);
    end
  endtask

  task automatic test_back_to_back();
    addr_t e0, e1;
    drive_phase(32'h8400_0000, 3'b010, 1'b1);
    #1;
    n_tests++;
    if ({valid, tempselx} !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b_decode: got valid=%b sel=%b, want 1 010", valid, tempselx);
    end
    addr_q.push_back('{addr: 32'h8400_0000, wr: 1'b1});
    step();
    drive_phase(32'h8400_0004, 3'b010, 1'b1);
    addr_q.push_back('{addr: 32'h8400_0004, wr: 1'b1});
    step();
    drive_idle();
    e0 = addr_q.pop_front();
    e1 = addr_q.pop_front();
    n_tests++;
    if ({Haddr2, Haddr1} !== {e0.addr, e1.addr}) begin
      n_fail++;
      $display("FAIL b2b_pipe: got a2=%h a1=%h, want a2=%h a1=%h", Haddr2, Haddr1, e0.addr, e1.addr);
    end
  endtask

  // Drive one illegal phase and walk the full ERR1/ERR2/OKAY sequence.
  task automatic error_seq(input logic [31:0] a, input logic [2:0] sz, input string name);
    drive_phase(a, sz, 1'b0);
    #1;
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_valid: got %b, want 0", name, valid);
    end
    rsp_q.push_back('{rdy: 1'b0, resp: 2'b01});
    rsp_q.push_back('{rdy: 1'b1, resp: 2'b01});
    rsp_q.push_back('{rdy: 1'b1, resp: 2'b00});
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    for (int i = 0; i < 3; i++) begin
      step();
      drive_idle();
      #1;
      check_rsp(name);
    end
  endtask

  task automatic test_error();
    error_seq(32'h9000_0000, 3'b010, "unmapped");
    n_tests++;
    if (err_count !== exp_err[7:0]) begin
      n_fail++;
      $display("FAIL err_count1: got %0d, want %0d", err_count, exp_err);
    end
  endtask

  task automatic test_size_align();
    Hreset = 1'b1;
    step();
    Hreset  = 1'b0;
    exp_err = 0;
    error_seq(32'h8800_0002, 3'b010, "misaligned_word");
    error_seq(32'h8800_0000, 3'b011, "oversize");
    n_tests++;
    if (err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL err_count2: got %0d, want 2", err_count);
    end
    error_seq(32'h8000_0001, 3'b001, "misaligned_half");
    drive_phase(32'h8000_0002, 3'b001, 1'b0);
    #1;
    n_tests++;
    if ({valid, tempselx} !== 4'b1001) begin
      n_fail++;
      $display("FAIL half_ok: got valid=%b sel=%b, want 1 001", valid, tempselx);
    end
    step();
    drive_idle();
  endtask

  task automatic test_reentry();
    drive_phase(32'h9000_0000, 3'b010, 1'b0);
    rsp_q.push_back('{rdy: 1'b0, resp: 2'b01});
    rsp_q.push_back('{rdy: 1'b1, resp: 2'b01});
    rsp_q.push_back('{rdy: 1'b0, resp: 2'b01});
    rsp_q.push_back('{rdy: 1'b1, resp: 2'b01});
    rsp_q.push_back('{rdy: 1'b1, resp: 2'b00});
    exp_err += 2;
    step();
    drive_idle();
    #1;
    check_rsp("reentry_err1");
    step();
    // Illegal phase presented while ERROR is completing.
    drive_phase(32'hF000_0000, 3'b000, 1'b0);
    #1;
    check_rsp("reentry_err2");
    for (int i = 0; i < 3; i++) begin
      step();
      drive_idle();
      #1;
      check_rsp("reentry_tail");
    end
    n_tests++;
    if (err_count !== exp_err[7:0]) begin
      n_fail++;
      $display("FAIL reentry_count: got %0d, want %0d", err_count, exp_err);
    end
  endtask

  task automatic test_inactive();
    logic [31:0] held;
    drive_phase(32'h8000_0040, 3'b010, 1'b0);
    step();
    held = 32'h8000_0040;
    for (int i = 0; i < 2; i++) begin
      drive_phase(32'h8000_0044, 3'b010, 1'b0);
      Htrans = (i == 0) ? 2'b01 : 2'b00;
      #1;
      n_tests++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL inactive_valid: got %b, want 0 (htrans=%b)", valid, Htrans);
      end
      step();
      n_tests++;
      if ({Hreadyout, Hresp, err_count} !== {1'b1, 2'b00, exp_err[7:0]}) begin
        n_fail++;
        $display("FAIL inactive_noerr: got rdy=%b resp=%b cnt=%0d, want 1 00 %0d",
                 Hreadyout, Hresp, err_count, exp_err);
      end
    end
    held = 32'h8000_0044;
    drive_phase(32'h9000_0000, 3'b010, 1'b1);
    Hreadyin = 1'b0;
    #1;
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL notready_valid: got %b, want 0", valid);
    end
    step();
    n_tests++;
    if ({Haddr1, Hresp, err_count} !== {held, 2'b00, exp_err[7:0]}) begin
      n_fail++;
      $display("FAIL notready_hold: got a1=%h resp=%b cnt=%0d, want a1=%h resp=00 cnt=%0d",
               Haddr1, Hresp, err_count, held, exp_err);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_err();
    drive_phase(32'h9000_0000, 3'b010, 1'b0);
    step();
    drive_idle();
    Hreset = 1'b1;
    #1;
    exp_err = 0;
    n_tests++;
    if ({Hresp, Hreadyout, err_count} !== {2'b00, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_err: got resp=%b rdy=%b cnt=%0d, want 00 1 0",
               Hresp, Hreadyout, err_count);
    end
    step();
    Hreset = 1'b0;
  endtask

  task automatic test_saturate();
    for (int n = 1; n <= 258; n++) begin
      drive_phase(32'h0000_0000, 3'b010, 1'b0);
      step();
      drive_idle();
      step();
      step();
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      if (n == 254 || n == 255 || n == 258) begin
        n_tests++;
        if (err_count !== exp_err[7:0]) begin
          n_fail++;
          $display("FAIL saturate_%0d: got %0d, want %0d", n, err_count, exp_err);
        end
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    exp_err       = 0;
    Hreset        = 1'b1;
    Hwrite        = 1'b0;
    Hreadyin      = 1'b1;
    Htrans        = 2'b00;
    Hsize         = 3'b010;
    Haddr         = 32'h0;
    Hwdata        = 32'h0;
    Prdata        = 32'h0;
    Hreadyout_apb = 1'b1;
    test_reset();
    test_write();
    test_back_to_back();
    test_error();
    test_size_align();
    test_reentry();
    test_inactive();
    test_reset_mid_err();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the sequence is cycle-driven, so this only trips on a bench hang.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
